// File: rtl/id_ex_if.sv
// ID -> EX pipeline register bundle: ID-side inputs, EX-side registered outputs and the upstream stall.
// With ID_EX_PERF_CNT_EN defined, the bundle also carries the stall/flush event counters.
interface id_ex_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
);
    logic             valid_in;
    logic [6:0]       opcode_in;
    logic             Regwrite_in;
    logic             ALUsrc_in;
    logic             Memtoreg_in;
    logic             Memread_in;
    logic             Memwrite_in;
    logic             Branch_in;
    logic [XLEN-1:0]  pc_in;
    logic [XLEN-1:0]  rs1_data_in;
    logic [XLEN-1:0]  rs2_data_in;
    logic [XLEN-1:0]  imm_in;
    logic [RADDR-1:0] rs1_in;
    logic [RADDR-1:0] rs2_in;
    logic [RADDR-1:0] rd_in;
    logic [2:0]       funct3_in;
    logic             funct7b5_in;
    logic             flush;

    logic             Regwrite_out;
    logic             ALUsrc_out;
    logic             Memtoreg_out;
    logic             Memread_out;
    logic             Memwrite_out;
    logic             Branch_out;
    logic [XLEN-1:0]  pc_out;
    logic [XLEN-1:0]  rs1_data_out;
    logic [XLEN-1:0]  rs2_data_out;
    logic [XLEN-1:0]  imm_out;
    logic [RADDR-1:0] rs1_out;
    logic [RADDR-1:0] rs2_out;
    logic [RADDR-1:0] rd_out;
    logic [2:0]       funct3_out;
    logic             funct7b5_out;
    logic             valid_out;
    logic             stall_out;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]      stall_cnt;
    logic [31:0]      flush_cnt;

    modport master (
        output valid_in, opcode_in, Regwrite_in, ALUsrc_in, Memtoreg_in, Memread_in,
               Memwrite_in, Branch_in, pc_in, rs1_data_in, rs2_data_in, imm_in,
               rs1_in, rs2_in, rd_in, funct3_in, funct7b5_in, flush,
        input  Regwrite_out, ALUsrc_out, Memtoreg_out, Memread_out, Memwrite_out,
               Branch_out, pc_out, rs1_data_out, rs2_data_out, imm_out, rs1_out,
               rs2_out, rd_out, funct3_out, funct7b5_out, valid_out, stall_out,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  valid_in, opcode_in, Regwrite_in, ALUsrc_in, Memtoreg_in, Memread_in,
               Memwrite_in, Branch_in, pc_in, rs1_data_in, rs2_data_in, imm_in,
               rs1_in, rs2_in, rd_in, funct3_in, funct7b5_in, flush,
        output Regwrite_out, ALUsrc_out, Memtoreg_out, Memread_out, Memwrite_out,
               Branch_out, pc_out, rs1_data_out, rs2_data_out, imm_out, rs1_out,
               rs2_out, rd_out, funct3_out, funct7b5_out, valid_out, stall_out,
               stall_cnt, flush_cnt
    );
`else
    modport master (
        output valid_in, opcode_in, Regwrite_in, ALUsrc_in, Memtoreg_in, Memread_in,
               Memwrite_in, Branch_in, pc_in, rs1_data_in, rs2_data_in, imm_in,
               rs1_in, rs2_in, rd_in, funct3_in, funct7b5_in, flush,
        input  Regwrite_out, ALUsrc_out, Memtoreg_out, Memread_out, Memwrite_out,
               Branch_out, pc_out, rs1_data_out, rs2_data_out, imm_out, rs1_out,
               rs2_out, rd_out, funct3_out, funct7b5_out, valid_out, stall_out
    );

    modport slave (
        input  valid_in, opcode_in, Regwrite_in, ALUsrc_in, Memtoreg_in, Memread_in,
               Memwrite_in, Branch_in, pc_in, rs1_data_in, rs2_data_in, imm_in,
               rs1_in, rs2_in, rd_in, funct3_in, funct7b5_in, flush,
        output Regwrite_out, ALUsrc_out, Memtoreg_out, Memread_out, Memwrite_out,
               Branch_out, pc_out, rs1_data_out, rs2_data_out, imm_out, rs1_out,
               rs2_out, rd_out, funct3_out, funct7b5_out, valid_out, stall_out
    );
`endif
endinterface

// File: rtl/id_ex_stage.sv
// RV32I ID/EX pipeline register with load-use hazard bubble/stall and taken-branch squash.
// Optional macro ID_EX_PERF_CNT_EN adds wrapping 32-bit stall/flush event counters.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic       clk,
    input  logic       rst,
    id_ex_if.slave     bus
);

    // Returns {rs1_used, rs2_used}; unrecognised opcodes use neither operand.
    function automatic logic [1:0] f_operand_use(input logic [6:0] i_op);
        logic [1:0] v_use;
        case (i_op)
            7'b0110111, 7'b0010111, 7'b1101111: v_use = 2'b00;
            7'b0110011, 7'b0100011, 7'b1100011: v_use = 2'b11;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b0001111, 7'b1110011:             v_use = 2'b10;
            default:                            v_use = 2'b00;
        endcase
        return v_use;
    endfunction

    logic             r_regwrite;
    logic             r_alusrc;
    logic             r_memtoreg;
    logic             r_memread;
    logic             r_memwrite;
    logic             r_branch;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_imm;
    logic [RADDR-1:0] r_rs1;
    logic [RADDR-1:0] r_rs2;
    logic [RADDR-1:0] r_rd;
    logic [2:0]       r_funct3;
    logic             r_funct7b5;
    logic             r_valid;

    logic [1:0]       w_use;
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_hazard;
    logic             w_stall;
    logic             w_load;

    // Load-use hazard against the load currently sitting in EX.
    always_comb begin
        w_use     = f_operand_use(bus.opcode_in);
        w_rs1_hit = w_use[1] & (bus.rs1_in == r_rd);
        w_rs2_hit = w_use[0] & (bus.rs2_in == r_rd);
        w_hazard  = bus.valid_in & r_valid & r_memread & (r_rd != {RADDR{1'b0}})
                  & (w_rs1_hit | w_rs2_hit);
        w_stall   = w_hazard & ~bus.flush & ~rst;
        w_load    = bus.valid_in & ~bus.flush & ~w_hazard;
    end

    // Pipeline register: capture the ID instruction or load an all-zero bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_branch   <= 1'b0;
            r_pc       <= {XLEN{1'b0}};
            r_rs1_data <= {XLEN{1'b0}};
            r_rs2_data <= {XLEN{1'b0}};
            r_imm      <= {XLEN{1'b0}};
            r_rs1      <= {RADDR{1'b0}};
            r_rs2      <= {RADDR{1'b0}};
            r_rd       <= {RADDR{1'b0}};
            r_funct3   <= 3'b000;
            r_funct7b5 <= 1'b0;
            r_valid    <= 1'b0;
        end else if (w_load) begin
            r_regwrite <= bus.Regwrite_in;
            r_alusrc   <= bus.ALUsrc_in;
            r_memtoreg <= bus.Memtoreg_in;
            r_memread  <= bus.Memread_in;
            r_memwrite <= bus.Memwrite_in;
            r_branch   <= bus.Branch_in;
            r_pc       <= bus.pc_in;
            r_rs1_data <= bus.rs1_data_in;
            r_rs2_data <= bus.rs2_data_in;
            r_imm      <= bus.imm_in;
            r_rs1      <= bus.rs1_in;
            r_rs2      <= bus.rs2_in;
            r_rd       <= bus.rd_in;
            r_funct3   <= bus.funct3_in;
            r_funct7b5 <= bus.funct7b5_in;
            r_valid    <= 1'b1;
        end else begin
            r_regwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_branch   <= 1'b0;
            r_pc       <= {XLEN{1'b0}};
            r_rs1_data <= {XLEN{1'b0}};
            r_rs2_data <= {XLEN{1'b0}};
            r_imm      <= {XLEN{1'b0}};
            r_rs1      <= {RADDR{1'b0}};
            r_rs2      <= {RADDR{1'b0}};
            r_rd       <= {RADDR{1'b0}};
            r_funct3   <= 3'b000;
            r_funct7b5 <= 1'b0;
            r_valid    <= 1'b0;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Free-running event counters; natural 32-bit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            r_stall_cnt <= w_stall   ? r_stall_cnt + 32'd1 : r_stall_cnt;
            r_flush_cnt <= bus.flush ? r_flush_cnt + 32'd1 : r_flush_cnt;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`endif

    assign bus.Regwrite_out = r_regwrite;
    assign bus.ALUsrc_out   = r_alusrc;
    assign bus.Memtoreg_out = r_memtoreg;
    assign bus.Memread_out  = r_memread;
    assign bus.Memwrite_out = r_memwrite;
    assign bus.Branch_out   = r_branch;
    assign bus.pc_out       = r_pc;
    assign bus.rs1_data_out = r_rs1_data;
    assign bus.rs2_data_out = r_rs2_data;
    assign bus.imm_out      = r_imm;
    assign bus.rs1_out      = r_rs1;
    assign bus.rs2_out      = r_rs2;
    assign bus.rd_out       = r_rd;
    assign bus.funct3_out   = r_funct3;
    assign bus.funct7b5_out = r_funct7b5;
    assign bus.valid_out    = r_valid;
    assign bus.stall_out    = w_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (load-use stall, flush, reset, optional counters).
module tb_id_ex_stage;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // {Regwrite, ALUsrc, Memtoreg, Memread, Memwrite, Branch}
    localparam logic [5:0] C_LW   = 6'b111100;
    localparam logic [5:0] C_SW   = 6'b010010;
    localparam logic [5:0] C_ADD  = 6'b100000;
    localparam logic [5:0] C_ADDI = 6'b110000;
    localparam logic [5:0] C_LUI  = 6'b110000;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    id_ex_if #(.XLEN(32), .RADDR(5)) bus ();

    id_ex_stage #(.XLEN(32), .RADDR(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic v, input logic [6:0] op, input logic [5:0] c,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] imm);
        bus.valid_in    = v;
        bus.opcode_in   = op;
        bus.Regwrite_in = c[5];
        bus.ALUsrc_in   = c[4];
        bus.Memtoreg_in = c[3];
        bus.Memread_in  = c[2];
        bus.Memwrite_in = c[1];
        bus.Branch_in   = c[0];
        bus.pc_in       = 32'h0000_1000 + {imm[29:0], 2'b00};
        bus.rs1_data_in = 32'hA000_0000 | {27'd0, rs1};
        bus.rs2_data_in = 32'hB000_0000 | {27'd0, rs2};
        bus.imm_in      = imm;
        bus.rs1_in      = rs1;
        bus.rs2_in      = rs2;
        bus.rd_in       = rd;
        bus.funct3_in   = 3'b010;
        bus.funct7b5_in = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush = 1'b0;
        set_ins(1'b1, OP_LW, 6'($urandom), 5'($urandom), 5'($urandom), 5'd9, $urandom);
        #3;
        chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_out}, 32'd0);
        step();
        chk("rst_regwrite", {31'd0, bus.Regwrite_out}, 32'd0);
        chk("rst_pc", bus.pc_out, 32'd0);
        chk("rst_imm", bus.imm_out, 32'd0);
        chk("rst_rd", {27'd0, bus.rd_out}, 32'd0);
        rst = 1'b0;
        set_ins(1'b1, OP_ADDI, C_ADDI, 5'd1, 5'd0, 5'd5, 32'h10);
        step();
        chk("addi_regwrite", {31'd0, bus.Regwrite_out}, 32'd1);
        chk("addi_alusrc", {31'd0, bus.ALUsrc_out}, 32'd1);
        chk("addi_memread", {31'd0, bus.Memread_out}, 32'd0);
        chk("addi_rd", {27'd0, bus.rd_out}, 32'd5);
        chk("addi_imm", bus.imm_out, 32'h10);
        chk("addi_valid", {31'd0, bus.valid_out}, 32'd1);
        chk("addi_pc", bus.pc_out, 32'h0000_1040);
    endtask

    task automatic test_load_use();
        set_ins(1'b1, OP_LW, C_LW, 5'd1, 5'd0, 5'd3, 32'h4);
        step();
        chk("lu_ex_memread", {31'd0, bus.Memread_out}, 32'd1);
        set_ins(1'b1, OP_ADD, C_ADD, 5'd3, 5'd4, 5'd6, 32'h0);
        #1;
        chk("lu_stall", {31'd0, bus.stall_out}, 32'd1);
        step();
        chk("lu_bubble_regwrite", {31'd0, bus.Regwrite_out}, 32'd0);
        chk("lu_bubble_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("lu_bubble_rd", {27'd0, bus.rd_out}, 32'd0);
        chk("lu_stall_drop", {31'd0, bus.stall_out}, 32'd0);
        step();
        chk("lu_add_valid", {31'd0, bus.valid_out}, 32'd1);
        chk("lu_add_rs1", {27'd0, bus.rs1_out}, 32'd3);
        chk("lu_add_rs2", {27'd0, bus.rs2_out}, 32'd4);
        chk("lu_add_rs2data", bus.rs2_data_out, 32'hB000_0004);
        chk("lu_add_regwrite", {31'd0, bus.Regwrite_out}, 32'd1);
    endtask

    task automatic test_no_false_stall();
        set_ins(1'b1, OP_LW, C_LW, 5'd1, 5'd0, 5'd3, 32'h8);
        step();
        set_ins(1'b1, OP_LUI, C_LUI, 5'd3, 5'd3, 5'd3, 32'h12345000);
        #1;
        chk("lui_no_stall", {31'd0, bus.stall_out}, 32'd0);
        step();
        chk("lui_captured", bus.imm_out, 32'h12345000);
        set_ins(1'b1, OP_LW, C_LW, 5'd1, 5'd0, 5'd0, 32'h8);
        step();
        set_ins(1'b1, OP_ADD, C_ADD, 5'd0, 5'd0, 5'd2, 32'h0);
        #1;
        chk("x0_no_stall", {31'd0, bus.stall_out}, 32'd0);
        step();
        chk("x0_add_valid", {31'd0, bus.valid_out}, 32'd1);
    endtask

    task automatic test_rs2_usage();
        set_ins(1'b1, OP_LW, C_LW, 5'd1, 5'd0, 5'd7, 32'h8);
        step();
        set_ins(1'b1, OP_ADDI, C_ADDI, 5'd2, 5'd7, 5'd8, 32'h1);
        #1;
        chk("addi_rs2_no_stall", {31'd0, bus.stall_out}, 32'd0);
        step();
        set_ins(1'b1, OP_LW, C_LW, 5'd1, 5'd0, 5'd7, 32'h8);
        step();
        set_ins(1'b1, OP_SW, C_SW, 5'd2, 5'd7, 5'd0, 32'h4);
        #1;
        chk("sw_rs2_stall", {31'd0, bus.stall_out}, 32'd1);
        step();
        chk("sw_bubble_valid", {31'd0, bus.valid_out}, 32'd0);
        step();
        chk("sw_memwrite", {31'd0, bus.Memwrite_out}, 32'd1);
    endtask

    task automatic test_flush_priority();
        set_ins(1'b1, OP_LW, C_LW, 5'd1, 5'd0, 5'd3, 32'h8);
        step();
        set_ins(1'b1, OP_ADD, C_ADD, 5'd3, 5'd4, 5'd6, 32'h0);
        bus.flush = 1'b1;
        #1;
        chk("flush_no_stall", {31'd0, bus.stall_out}, 32'd0);
        step();
        bus.flush = 1'b0;
        chk("flush_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("flush_memread", {31'd0, bus.Memread_out}, 32'd0);
        chk("flush_pc", bus.pc_out, 32'd0);
        set_ins(1'b0, OP_ADD, C_ADD, 5'd1, 5'd2, 5'd3, 32'h7);
        step();
        chk("vin0_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("vin0_regwrite", {31'd0, bus.Regwrite_out}, 32'd0);
    endtask

    task automatic test_back_to_back();
        int stalls;
        stalls = 0;
        set_ins(1'b1, OP_LW, C_LW, 5'd1, 5'd0, 5'd3, 32'h8);
        step();
        set_ins(1'b1, OP_LW, C_LW, 5'd3, 5'd0, 5'd4, 32'hC);
        for (int i = 0; i < 2; i++) begin
            #1;
            if (bus.stall_out === 1'b1) stalls++;
            step();
        end
        chk("b2b_lw2_rd", {27'd0, bus.rd_out}, 32'd4);
        set_ins(1'b1, OP_ADD, C_ADD, 5'd4, 5'd5, 5'd9, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            if (bus.stall_out === 1'b1) stalls++;
            step();
        end
        chk("b2b_stall_count", stalls, 32'd2);
        chk("b2b_add_rs1", {27'd0, bus.rs1_out}, 32'd4);
    endtask

    task automatic test_reset_mid_stall();
        set_ins(1'b1, OP_LW, C_LW, 5'd1, 5'd0, 5'd3, 32'h8);
        step();
        set_ins(1'b1, OP_ADD, C_ADD, 5'd3, 5'd4, 5'd6, 32'h0);
        #1;
        chk("mid_stall_pre", {31'd0, bus.stall_out}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_async_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("mid_async_memread", {31'd0, bus.Memread_out}, 32'd0);
        chk("mid_async_stall", {31'd0, bus.stall_out}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk("mid_async_scnt", bus.stall_cnt, 32'd0);
        chk("mid_async_fcnt", bus.flush_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_valid", {31'd0, bus.valid_out}, 32'd1);
        chk("post_rst_rs1", {27'd0, bus.rs1_out}, 32'd3);
`ifdef ID_EX_PERF_CNT_EN
        set_ins(1'b1, OP_LW, C_LW, 5'd1, 5'd0, 5'd3, 32'h8);
        step();
        set_ins(1'b1, OP_ADD, C_ADD, 5'd3, 5'd4, 5'd6, 32'h0);
        step();
        bus.flush = 1'b1;
        step();
        step();
        bus.flush = 1'b0;
        chk("perf_stall_cnt", bus.stall_cnt, 32'd1);
        chk("perf_flush_cnt", bus.flush_cnt, 32'd2);
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_rs2_usage();
        test_flush_priority();
        test_back_to_back();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
